// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state encoding, default watchdog limit and result-flag bundle
// for the comparator initiator.
package cmp_pkg;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   localparam int CMP_TIMEOUT = 15;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } flags_t;

   // cout is greater-than, z_flag is equal; less-than is whatever remains.
   function automatic flags_t flags_from(input logic cout, input logic z);
      return '{gt: cout & ~z, eq: z, lt: ~cout & ~z};
   endfunction
endpackage

// File: rtl/cmp_initiator_if.sv
// cmp_initiator_if: request side and comparator side of the initiator.
// master is the initiator's view; slave is the requester/comparator view.
interface cmp_initiator_if #(
   parameter int WIDTH = 1
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic             gt;
   logic             eq;
   logic             lt;
   logic             err;
   logic             cs_cmp;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             cout;
   logic             z_flag;

   modport master (
      input  start, op_a, op_b, ready, cout, z_flag,
      output busy, done, gt, eq, lt, err, cs_cmp, a, b
   );

   modport slave (
      output start, op_a, op_b, ready, cout, z_flag,
      input  busy, done, gt, eq, lt, err, cs_cmp, a, b
   );
endinterface

// File: rtl/cmp_wdog.sv
// cmp_wdog: loadable down-counter watchdog; expires on the last counted cycle
// and keeps expiring once it has run out.
module cmp_wdog
   import cmp_pkg::*;
#(
   parameter int TIMEOUT = CMP_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_load,
   input  logic i_en,
   output logic o_expire
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= CW'(TIMEOUT);
      else if (i_en && r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_expire = i_en && (r_cnt <= CW'(1));
endmodule

// File: rtl/cmp_initiator.sv
// cmp_initiator: requester-side controller for the comparator unit; issues a
// chip-select handshake, captures gt/eq/lt and aborts stalled transactions.
module cmp_initiator
   import cmp_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter int TIMEOUT = CMP_TIMEOUT
) (
   input logic             clk,
   input logic             rst_n,
   cmp_initiator_if.master bus
);
   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_cs;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   flags_t           r_flags;
   logic             w_accept;
   logic             w_ack;
   logic             w_fin;
   logic             w_expire;
   logic             w_abort;

   assign w_accept = (r_state == IDLE) && bus.start && bus.ready;
   assign w_ack    = (r_state == REQ) && !bus.ready;
   assign w_fin    = (r_state == WAIT) && bus.ready;
   // A ready transition in the expiry cycle takes priority over the abort.
   assign w_abort  = w_expire && !w_ack && !w_fin;

   cmp_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    (w_fin || w_abort),
      .i_load   (w_accept),
      .i_en     (r_state != IDLE),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_cs    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_flags <= '0;
      end else begin
         r_done <= w_fin || w_abort;
         if (w_accept) begin
            r_state <= REQ;
            r_a     <= bus.op_a;
            r_b     <= bus.op_b;
            r_cs    <= 1'b1;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
         end else if (w_ack) begin
            r_state <= WAIT;
            r_cs    <= 1'b0;
         end else if (w_fin) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_flags <= flags_from(bus.cout, bus.z_flag);
         end else if (w_abort) begin
            r_state <= IDLE;
            r_cs    <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
         end
      end
   end

   assign bus.busy                 = r_busy;
   assign bus.done                 = r_done;
   assign {bus.gt, bus.eq, bus.lt} = r_flags;
   assign bus.err                  = r_err;
   assign bus.cs_cmp               = r_cs;
   assign bus.a                    = r_a;
   assign bus.b                    = r_b;
endmodule

// File: tb/tb_cmp_initiator.sv
// tb_cmp_initiator: directed and randomized checks of cmp_initiator against a
// transaction-level model, with a behavioural comparator responder.
module tb_cmp_initiator;
   localparam int W  = 1;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cmp_initiator_if #(.WIDTH(W)) bus ();
   cmp_initiator #(.WIDTH(W), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Comparator responder: ready drops on a select, returns after rsp_delay cycles.
   logic         rsp_ready = 1'b1;
   logic         rsp_cout = 1'b0;
   logic         rsp_z = 1'b0;
   logic [W-1:0] rsp_a = '0;
   logic [W-1:0] rsp_b = '0;
   int           rsp_cnt = 0;
   int           rsp_delay = 2;
   logic         rsp_noack = 1'b0;
   logic         rsp_hang = 1'b0;
   logic         force_low = 1'b0;

   assign bus.ready  = rsp_ready & ~force_low;
   assign bus.cout   = rsp_cout;
   assign bus.z_flag = rsp_z;

   always @(posedge clk) begin
      if (!rsp_ready) begin
         if (!rsp_hang) begin
            if (rsp_cnt <= 1) begin
               rsp_ready <= 1'b1;
               rsp_cout  <= rsp_a > rsp_b;
               rsp_z     <= rsp_a == rsp_b;
            end else
               rsp_cnt <= rsp_cnt - 1;
         end
      end else if (bus.cs_cmp && !force_low && !rsp_noack) begin
         rsp_ready <= 1'b0;
         rsp_a     <= bus.a;
         rsp_b     <= bus.b;
         rsp_cnt   <= rsp_delay;
      end
   end

   // Transaction model: age counts cycles since acceptance, acked marks the ready drop.
   bit         m_busy, m_acked, m_cs, m_done, m_gt, m_eq, m_lt, m_err;
   logic [W-1:0] m_a, m_b;
   int         m_n;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {m_busy, m_acked, m_cs, m_done, m_gt, m_eq, m_lt, m_err} = '0;
         m_a = '0;
         m_b = '0;
         m_n = 0;
      end else begin
         m_done = 1'b0;
         if (!m_busy) begin
            if (bus.start && bus.ready) begin
               m_busy  = 1'b1;
               m_acked = 1'b0;
               m_cs    = 1'b1;
               m_err   = 1'b0;
               m_n     = 0;
               m_a     = bus.op_a;
               m_b     = bus.op_b;
            end
         end else begin
            m_n++;
            if (!m_acked && !bus.ready) begin
               m_acked = 1'b1;
               m_cs    = 1'b0;
            end else if (m_acked && bus.ready) begin
               m_gt   = m_a > m_b;
               m_eq   = m_a == m_b;
               m_lt   = m_a < m_b;
               m_done = 1'b1;
               m_busy = 1'b0;
            end else if (m_n >= TO) begin
               m_cs   = 1'b0;
               m_err  = 1'b1;
               m_done = 1'b1;
               m_busy = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("gt", bus.gt, m_gt);
      chk("eq", bus.eq, m_eq);
      chk("lt", bus.lt, m_lt);
      chk("err", bus.err, m_err);
      chk("cs_cmp", bus.cs_cmp, m_cs);
      chk("a", bus.a, m_a);
      chk("b", bus.b, m_b);
   end

   task automatic all_zero(input string nm);
      chk({nm, "_busy"}, bus.busy, 0);
      chk({nm, "_done"}, bus.done, 0);
      chk({nm, "_flags"}, {bus.gt, bus.eq, bus.lt}, 0);
      chk({nm, "_err"}, bus.err, 0);
      chk({nm, "_cs"}, bus.cs_cmp, 0);
      chk({nm, "_ab"}, {bus.a, bus.b}, 0);
   endtask

   // Call at a negedge; k=0 is the sample just after the accepting edge.
   task automatic txn(input logic va, input logic vb, input bit hold,
                      output int cs_n, output int done_at);
      bus.start = 1'b1;
      bus.op_a  = va;
      bus.op_b  = vb;
      cs_n      = 0;
      done_at   = -1;
      for (int k = 0; k < 40 && done_at < 0; k++) begin
         @(negedge clk);
         if (!hold) bus.start = 1'b0;
         cs_n += int'(bus.cs_cmp);
         if (bus.done) done_at = k;
      end
   endtask

   initial begin
      int cs_n, done_at, dones, accs, guard;
      logic prev_busy;
      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      repeat (3) @(negedge clk);
      all_zero("reset");
      force_low = 1'b1;
      bus.start = 1'b1;
      bus.op_a  = 1'b1;
      #2 rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("no_cs_not_ready", bus.cs_cmp, 0);
         chk("no_busy_not_ready", bus.busy, 0);
      end
      force_low = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);

      txn(1'b1, 1'b0, 1'b0, cs_n, done_at);
      chk("t2_cs_cycles", cs_n, 2);
      chk("t2_done_at", done_at, 4);
      chk("t2_flags", {bus.gt, bus.eq, bus.lt, bus.err}, 4'b1000);

      txn(1'b0, 1'b0, 1'b1, cs_n, done_at);
      chk("t3a_done_at", done_at, 4);
      chk("t3a_flags", {bus.gt, bus.eq, bus.lt}, 3'b010);
      txn(1'b0, 1'b1, 1'b0, cs_n, done_at);
      chk("t3b_done_at", done_at, 4);
      chk("t3b_flags", {bus.gt, bus.eq, bus.lt}, 3'b001);

      rsp_noack = 1'b1;
      txn(1'b1, 1'b1, 1'b0, cs_n, done_at);
      chk("t4_done_at", done_at, 15);
      chk("t4_cs_cycles", cs_n, 15);
      chk("t4_state", {bus.err, bus.busy, bus.cs_cmp}, 3'b100);
      chk("t4_flags_kept", {bus.gt, bus.eq, bus.lt}, 3'b001);
      rsp_noack = 1'b0;
      @(negedge clk);

      rsp_delay = 6;
      bus.start = 1'b1;
      bus.op_a  = 1'b1;
      bus.op_b  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1 all_zero("async_reset");
      @(negedge clk);
      #2 rst_n = 1'b1;
      rsp_delay = 2;
      @(negedge clk);
      bus.start = 1'b1;
      guard = 0;
      while (!bus.ready && guard < 20) begin
         @(negedge clk);
         chk("t5_no_accept_not_ready", bus.busy, 0);
         guard++;
      end
      chk("t5_ready_returned", bus.ready, 1);
      txn(1'b1, 1'b1, 1'b0, cs_n, done_at);
      chk("t5_done_at", done_at, 4);
      chk("t5_flags", {bus.gt, bus.eq, bus.lt, bus.err}, 4'b0100);

      bus.start = 1'b1;
      bus.op_a  = 1'b1;
      bus.op_b  = 1'b0;
      dones = 0;
      accs = 0;
      prev_busy = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         dones += int'(bus.done);
         if (bus.busy && !prev_busy) accs++;
         prev_busy = bus.busy;
         bus.start = bus.busy ? k[0] : 1'b0;
      end
      chk("t6_accepts", accs, 1);
      chk("t6_dones", dones, 1);

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         bus.start = ($urandom % 4) != 0;
         bus.op_a  = W'($urandom);
         bus.op_b  = W'($urandom);
         rsp_delay = $urandom_range(1, 4);
         if ($urandom % 64 == 0) rsp_noack = ~rsp_noack;
         if ($urandom % 64 == 0) rsp_hang = ~rsp_hang;
         force_low = !m_busy && ($urandom % 16 == 0);
         if ($urandom % 400 == 0) begin
            #1 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
